// File: rtl/i2c_slave.sv
// I2C target with a small byte-wide register file.
// SCL/SDA are oversampled by clk, START/STOP are detected on the synced lines,
// and the target supports auto-incrementing register writes and reads.
// A registered host port exposes the register contents to the rest of the FPGA.
module i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int         REG_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2c_sclk,
  inout  wire               i2c_sdat,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  input  logic [REG_AW-1:0] host_addr,
  output logic [7:0]        host_rdata
);

  localparam int DEPTH = 1 << REG_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t            state;
  logic [2:0]        scl_sync;
  logic [2:0]        sda_sync;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [REG_AW-1:0] ptr;
  logic              sda_oe;
  logic              ack_on;
  logic              rw;
  logic [7:0]        mem [DEPTH];

  logic scl_s, scl_d, sda_s, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Open-drain output: only ever pull low or release.
  assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

  assign scl_s     = scl_sync[1];
  assign scl_d     = scl_sync[2];
  assign sda_s     = sda_sync[1];
  assign sda_d     = sda_sync[2];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  // Byte as it will look once the bit on the current rising edge is shifted in.
  assign rx_byte   = {shreg[6:0], sda_s};

  // Two-flop synchronizers plus one history flop; reset to idle-bus level so no false edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], i2c_sclk};
      sda_sync <= {sda_sync[1:0], i2c_sdat};
    end
  end

  // Protocol FSM, register-file writes and SDA drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      sda_oe    <= 1'b0;
      ack_on    <= 1'b0;
      rw        <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        busy    <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shreg[6:0] == DEV_ADDR) begin
                state <= ADDR_ACK;
                rw    <= sda_s;
                busy  <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          // ACK slot: first falling edge pulls low, second one ends the slot.
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe <= 1'b1;
              ack_on <= 1'b1;
            end else begin
              ack_on  <= 1'b0;
              bit_cnt <= '0;
              if (state == ADDR_ACK && rw) begin
                shreg  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          PTR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              ptr   <= rx_byte[REG_AW-1:0];
              state <= PTR_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              mem[ptr]  <= rx_byte;
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              wr_data   <= rx_byte;
              ptr       <= ptr + REG_AW'(1);
              state     <= WDATA_ACK;
            end
          end
          // Master samples on rising edges; next bit is presented on each falling edge.
          RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                ptr   <= ptr + REG_AW'(1);
                state <= RACK;
              end
            end else if (scl_fall) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          // Release for the master's ACK bit; on ACK the next byte starts at the following fall.
          RACK: begin
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b0;
              end else begin
                ack_on  <= 1'b0;
                bit_cnt <= '0;
                shreg   <= mem[ptr];
                sda_oe  <= ~mem[ptr][7];
                state   <= RDATA;
              end
            end else if (scl_rise) begin
              if (sda_s) state <= IGNORE;
              else       ack_on <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered host read port; a same-cycle write shows up one cycle later.
  always_ff @(posedge clk) begin
    if (reset) host_rdata <= '0;
    else       host_rdata <= mem[host_addr];
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: a bit-banged I2C master drives the bus,
// and a register-file/pointer model predicts writes, strobes and read data.
module tb_i2c_slave;

  localparam int T = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] host_addr = '0;
  wire        sda_line;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] host_rdata;

  pullup (sda_line);
  assign sda_line = m_sda ? 1'bz : 1'b0;

  always #5 clk = ~clk;

  i2c_slave #(.DEV_ADDR(7'h1A), .REG_AW(4)) dut (
    .clk(clk), .reset(reset), .i2c_sclk(scl), .i2c_sdat(sda_line),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .host_addr(host_addr), .host_rdata(host_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  model_mem [16];
  logic [3:0]  model_ptr;
  logic [11:0] exp_wr [$];
  logic [11:0] obs_wr [$];
  logic [7:0]  wbuf [8];
  logic [7:0]  rbuf [8];
  int          slave_low = 0;
  logic        busy_seen = 1'b0;

  // Bus observers: strobes, target pulling SDA while the master releases, busy.
  always @(negedge clk) begin
    if (wr_strobe) obs_wr.push_back({wr_addr, wr_data});
    if (m_sda && sda_line === 1'b0) slave_low++;
    if (busy) busy_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    m_sda = 1'b1; tick(T);
    scl = 1'b1;   tick(T);
    m_sda = 1'b0; tick(T);
    scl = 1'b0;   tick(2);
  endtask

  task automatic send_stop();
    m_sda = 1'b0; tick(T);
    scl = 1'b1;   tick(T);
    m_sda = 1'b1; tick(T);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; tick(T);
    scl = 1'b1; tick(T / 2);
    s = sda_line;
    tick(T - T / 2);
    scl = 1'b0; tick(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = (s === 1'b0);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      b = {b[6:0], s};
    end
    clock_bit(~send_ack, s);
  endtask

  task automatic xfer_write(input logic [6:0] a, input logic [7:0] p, input int n, output int acks);
    logic ack;
    acks = 0;
    send_start();
    write_byte({a, 1'b0}, ack); acks += ack ? 1 : 0;
    write_byte(p, ack);         acks += ack ? 1 : 0;
    for (int k = 0; k < n; k++) begin
      write_byte(wbuf[k], ack); acks += ack ? 1 : 0;
    end
    send_stop();
    $display("txn write addr=%02h ptr=%02h len=%0d acks=%0d", a, p, n, acks);
  endtask

  task automatic xfer_read(input int n, input logic set_ptr, input logic [7:0] p, output int acks);
    logic ack;
    acks = 0;
    send_start();
    if (set_ptr) begin
      write_byte(8'h34, ack); acks += ack ? 1 : 0;
      write_byte(p, ack);     acks += ack ? 1 : 0;
      send_start();
    end
    write_byte(8'h35, ack); acks += ack ? 1 : 0;
    for (int k = 0; k < n; k++) read_byte(k != n - 1, rbuf[k]);
    send_stop();
    $display("txn read set_ptr=%0b ptr=%02h len=%0d acks=%0d", set_ptr, p, n, acks);
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    tick(1);
    d = host_rdata;
  endtask

  // Reference: writes land at successive pointer values, wrapping within 16 registers.
  task automatic model_write(input logic [7:0] p, input int n);
    model_ptr = p[3:0];
    for (int k = 0; k < n; k++) begin
      model_mem[model_ptr] = wbuf[k];
      exp_wr.push_back({model_ptr, wbuf[k]});
      model_ptr = model_ptr + 4'd1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (wr_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
    vectors++; if ({wr_addr, wr_data} !== 12'h000) begin miscompares++; $display("FAIL reset_wr got=%03h exp=000", {wr_addr, wr_data}); end
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL reset_sda got=%b exp=1", sda_line); end
    for (int r = 0; r < 16; r++) begin
      host_read(4'(r), d);
      vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_reg%0d got=%02h exp=00", r, d); end
    end
  endtask

  task automatic test_write();
    int acks;
    logic [7:0] d;
    busy_seen = 1'b0;
    wbuf[0] = 8'h5A; wbuf[1] = 8'hA5;
    model_write(8'h03, 2);
    xfer_write(7'h1A, 8'h03, 2, acks);
    vectors++; if (acks !== 4) begin miscompares++; $display("FAIL write_acks got=%0d exp=4", acks); end
    vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL write_busy_seen got=%b exp=1", busy_seen); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_after_stop got=%b exp=0", busy); end
    vectors++; if (obs_wr.size() != exp_wr.size()) begin miscompares++; $display("FAIL write_strobe_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
      vectors++; if (obs_wr[k] !== exp_wr[k]) begin miscompares++; $display("FAIL write_strobe%0d got=%03h exp=%03h", k, obs_wr[k], exp_wr[k]); end
    end
    obs_wr.delete(); exp_wr.delete();
    host_read(4'd3, d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL write_reg3 got=%02h exp=5a", d); end
    host_read(4'd4, d);
    vectors++; if (d !== 8'hA5) begin miscompares++; $display("FAIL write_reg4 got=%02h exp=a5", d); end
  endtask

  task automatic test_read_rstart();
    int acks;
    xfer_read(2, 1'b1, 8'h03, acks);
    vectors++; if (acks !== 3) begin miscompares++; $display("FAIL rd_acks got=%0d exp=3", acks); end
    vectors++; if (rbuf[0] !== 8'h5A) begin miscompares++; $display("FAIL rd_byte0 got=%02h exp=5a", rbuf[0]); end
    vectors++; if (rbuf[1] !== 8'hA5) begin miscompares++; $display("FAIL rd_byte1 got=%02h exp=a5", rbuf[1]); end
    vectors++; if (obs_wr.size() != 0) begin miscompares++; $display("FAIL rd_no_strobe got=%0d exp=0", obs_wr.size()); end
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL rd_sda_released got=%b exp=1", sda_line); end
    model_ptr = 4'd5;
    obs_wr.delete();
  endtask

  task automatic test_addr_mismatch();
    int acks;
    logic [7:0] d;
    slave_low = 0; busy_seen = 1'b0;
    xfer_write(7'h11, 8'h00, 0, acks);
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL mm_acks got=%0d exp=0", acks); end
    vectors++; if (slave_low !== 0) begin miscompares++; $display("FAIL mm_sda_driven got=%0d exp=0", slave_low); end
    vectors++; if (busy_seen !== 1'b0) begin miscompares++; $display("FAIL mm_busy got=%b exp=0", busy_seen); end
    vectors++; if (obs_wr.size() != 0) begin miscompares++; $display("FAIL mm_strobe got=%0d exp=0", obs_wr.size()); end
    for (int r = 0; r < 16; r++) begin
      host_read(4'(r), d);
      vectors++; if (d !== model_mem[r]) begin miscompares++; $display("FAIL mm_reg%0d got=%02h exp=%02h", r, d, model_mem[r]); end
    end
    obs_wr.delete();
  endtask

  task automatic test_ptr_wrap();
    int acks;
    logic [7:0] d;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    model_write(8'h0F, 2);
    xfer_write(7'h1A, 8'h0F, 2, acks);
    vectors++; if (acks !== 4) begin miscompares++; $display("FAIL wrap_acks got=%0d exp=4", acks); end
    vectors++; if (obs_wr.size() != exp_wr.size()) begin miscompares++; $display("FAIL wrap_strobe_count got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
      vectors++; if (obs_wr[k] !== exp_wr[k]) begin miscompares++; $display("FAIL wrap_strobe%0d got=%03h exp=%03h", k, obs_wr[k], exp_wr[k]); end
    end
    obs_wr.delete(); exp_wr.delete();
    host_read(4'd15, d);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL wrap_reg15 got=%02h exp=11", d); end
    host_read(4'd0, d);
    vectors++; if (d !== 8'h22) begin miscompares++; $display("FAIL wrap_reg0 got=%02h exp=22", d); end
  endtask

  task automatic test_ptr_persist();
    int acks;
    model_write(8'h07, 0);
    xfer_write(7'h1A, 8'h07, 0, acks);
    xfer_read(1, 1'b0, 8'h00, acks);
    vectors++; if (acks !== 1) begin miscompares++; $display("FAIL persist_acks got=%0d exp=1", acks); end
    vectors++; if (rbuf[0] !== model_mem[7]) begin miscompares++; $display("FAIL persist_data got=%02h exp=%02h", rbuf[0], model_mem[7]); end
    model_ptr = 4'd8;
  endtask

  task automatic test_random();
    int acks, n;
    logic [7:0] p, e;
    logic sp;
    for (int it = 0; it < 10; it++) begin
      n = int'($urandom_range(1, 4));
      p = 8'($urandom);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
      model_write(p, n);
      xfer_write(7'h1A, p, n, acks);
      vectors++; if (acks !== n + 2) begin miscompares++; $display("FAIL rnd%0d_wacks got=%0d exp=%0d", it, acks, n + 2); end
      vectors++; if (obs_wr.size() != exp_wr.size()) begin miscompares++; $display("FAIL rnd%0d_strobe_count got=%0d exp=%0d", it, obs_wr.size(), exp_wr.size()); end
      for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
        vectors++; if (obs_wr[k] !== exp_wr[k]) begin miscompares++; $display("FAIL rnd%0d_strobe%0d got=%03h exp=%03h", it, k, obs_wr[k], exp_wr[k]); end
      end
      obs_wr.delete(); exp_wr.delete();
      n = int'($urandom_range(1, 4));
      sp = 1'($urandom);
      p = 8'($urandom);
      xfer_read(n, sp, p, acks);
      if (sp) model_ptr = p[3:0];
      for (int k = 0; k < n; k++) begin
        e = model_mem[model_ptr];
        model_ptr = model_ptr + 4'd1;
        vectors++; if (rbuf[k] !== e) begin miscompares++; $display("FAIL rnd%0d_rd%0d got=%02h exp=%02h", it, k, rbuf[k], e); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int acks;
    logic ack, s;
    logic [7:0] d, v;
    v = 8'($urandom) & 8'hDF;
    wbuf[0] = v;
    model_write(8'h05, 1);
    xfer_write(7'h1A, 8'h05, 1, acks);
    obs_wr.delete(); exp_wr.delete();
    send_start();
    write_byte(8'h34, ack);
    write_byte(8'h05, ack);
    send_start();
    write_byte(8'h35, ack);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    tick(4);
    vectors++; if (sda_line !== 1'b0) begin miscompares++; $display("FAIL rmr_bit3_driven got=%b exp=0", sda_line); end
    reset = 1'b1;
    tick(1);
    vectors++; if (sda_line !== 1'b1) begin miscompares++; $display("FAIL rmr_sda_release got=%b exp=1", sda_line); end
    tick(3);
    reset = 1'b0;
    $display("txn reset during read");
    for (int r = 0; r < 16; r++) model_mem[r] = 8'h00;
    model_ptr = 4'd0;
    for (int r = 0; r < 16; r++) begin
      host_read(4'(r), d);
      vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL rmr_reg%0d got=%02h exp=00", r, d); end
    end
    scl = 1'b1; tick(T);
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    model_write(8'h09, 2);
    xfer_write(7'h1A, 8'h09, 2, acks);
    vectors++; if (acks !== 4) begin miscompares++; $display("FAIL rmr_after_acks got=%0d exp=4", acks); end
    vectors++; if (obs_wr.size() != exp_wr.size()) begin miscompares++; $display("FAIL rmr_after_strobes got=%0d exp=%0d", obs_wr.size(), exp_wr.size()); end
    for (int k = 0; k < exp_wr.size() && k < obs_wr.size(); k++) begin
      vectors++; if (obs_wr[k] !== exp_wr[k]) begin miscompares++; $display("FAIL rmr_after_strobe%0d got=%03h exp=%03h", k, obs_wr[k], exp_wr[k]); end
    end
    obs_wr.delete(); exp_wr.delete();
    host_read(4'd10, d);
    vectors++; if (d !== model_mem[10]) begin miscompares++; $display("FAIL rmr_after_reg10 got=%02h exp=%02h", d, model_mem[10]); end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) model_mem[r] = 8'h00;
    model_ptr = 4'd0;
    tick(5);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_write();
    test_read_rstart();
    test_addr_mismatch();
    test_ptr_wrap();
    test_ptr_persist();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
